// File: rtl/arpas_dly_loader.sv
// Serial delay-word loader for the three-channel PAS timer: shifts three shadowed
// delay words over regdat/regclk/regsla/regslb, then opens the pdorun window.
// Optional build macro ARPAS_DLY_RANGE_EN rejects words that fall outside the run window.
//
// state      | meaning
// S_IDLE     | waiting for start, select parked at idle code 11
// S_SETUP    | channel select driven, settling before first strobe
// S_SHIFT_LO | data bit presented, regclk low
// S_SHIFT_HI | regclk high, data and select held
// S_NEXTCH   | select back to 11 for one cycle between channels
// S_RUN      | pdorun firing window
module arpas_dly_loader #(
  parameter int DW      = 13,
  parameter int HALF    = 2,
  parameter int RUN_LEN = 8192,
  parameter int SETTLE  = 2
) (
  input  logic          sysclk,
  input  logic          rstall,
  input  logic          start,
  input  logic          abort,
  input  logic [DW-1:0] dly_a,
  input  logic [DW-1:0] dly_b,
  input  logic [DW-1:0] dly_c,
  output logic          regdat,
  output logic          regclk,
  output logic          regsla,
  output logic          regslb,
  output logic          pdorun,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_SHIFT_LO, S_SHIFT_HI, S_NEXTCH, S_RUN
  } state_t;

  localparam logic [3:0]  SETTLE_M1 = 4'(SETTLE - 1);
  localparam logic [3:0]  HALF_M1   = 4'(HALF - 1);
  localparam logic [3:0]  LAST_BIT  = 4'(DW - 1);
  localparam logic [13:0] RUN_M1    = 14'(RUN_LEN - 1);

  state_t        state_q, state_d;
  logic [1:0]    ch_q, ch_d;
  logic [3:0]    bit_q, bit_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [13:0]   run_q, run_d;
  logic [DW-1:0] sh_a_q, sh_a_d, sh_b_q, sh_b_d, sh_c_q, sh_c_d;
  logic [DW-1:0] word;
  logic          sel_on, shifting;
  logic          regdat_q, regdat_d, regclk_q, regclk_d;
  logic          sla_q, sla_d, slb_q, slb_d;
  logic          pdorun_q, pdorun_d, busy_q, busy_d, done_q, done_d;

`ifdef ARPAS_DLY_RANGE_EN
  logic err_q, err_d;
  logic range_bad;
  assign range_bad = (32'(dly_a) >= 32'(RUN_LEN)) || (32'(dly_b) >= 32'(RUN_LEN)) ||
                     (32'(dly_c) >= 32'(RUN_LEN));
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    sh_a_d  = sh_a_q;
    sh_b_d  = sh_b_q;
    sh_c_d  = sh_c_q;
    done_d  = 1'b0;
`ifdef ARPAS_DLY_RANGE_EN
    err_d   = err_q;
`endif
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          sh_a_d = dly_a;
          sh_b_d = dly_b;
          sh_c_d = dly_c;
`ifdef ARPAS_DLY_RANGE_EN
          if (range_bad) err_d = 1'b1;
          else begin
            state_d = S_SETUP;
            ch_d    = 2'd0;
            bit_d   = 4'd0;
            cnt_d   = SETTLE_M1;
          end
`else
          state_d = S_SETUP;
          ch_d    = 2'd0;
          bit_d   = 4'd0;
          cnt_d   = SETTLE_M1;
`endif
        end
        S_SETUP: begin
          if (cnt_q == 4'd0) begin
            state_d = S_SHIFT_LO;
            cnt_d   = HALF_M1;
          end else cnt_d = cnt_q - 4'd1;
        end
        S_SHIFT_LO: begin
          if (cnt_q == 4'd0) begin
            state_d = S_SHIFT_HI;
            cnt_d   = HALF_M1;
          end else cnt_d = cnt_q - 4'd1;
        end
        S_SHIFT_HI: begin
          if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
          else if (bit_q < LAST_BIT) begin
            bit_d   = bit_q + 4'd1;
            cnt_d   = HALF_M1;
            state_d = S_SHIFT_LO;
          end else state_d = S_NEXTCH;
        end
        S_NEXTCH: begin
          if (ch_q == 2'd2) begin
            state_d = S_RUN;
            run_d   = RUN_M1;
          end else begin
            ch_d    = ch_q + 2'd1;
            bit_d   = 4'd0;
            cnt_d   = SETTLE_M1;
            state_d = S_SETUP;
          end
        end
        S_RUN: begin
          if (run_q == 14'd0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else run_d = run_q - 14'd1;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Outputs are decoded from the next state so every link pin comes straight off a flop.
    case (ch_d)
      2'd0:    word = sh_a_d;
      2'd1:    word = sh_b_d;
      default: word = sh_c_d;
    endcase
    shifting = (state_d == S_SHIFT_LO) || (state_d == S_SHIFT_HI);
    sel_on   = shifting || (state_d == S_SETUP);
    regdat_d = shifting & word[bit_d];
    regclk_d = (state_d == S_SHIFT_HI);
    sla_d    = !sel_on || (ch_d == 2'd1);
    slb_d    = !sel_on || (ch_d == 2'd2);
    pdorun_d = (state_d == S_RUN);
    busy_d   = (state_d != S_IDLE);
  end

  always_ff @(posedge sysclk or negedge rstall) begin
    if (!rstall) begin
      state_q  <= S_IDLE;
      ch_q     <= 2'd0;
      bit_q    <= 4'd0;
      cnt_q    <= 4'd0;
      run_q    <= 14'd0;
      sh_a_q   <= '0;
      sh_b_q   <= '0;
      sh_c_q   <= '0;
      regdat_q <= 1'b0;
      regclk_q <= 1'b0;
      sla_q    <= 1'b1;
      slb_q    <= 1'b1;
      pdorun_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef ARPAS_DLY_RANGE_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      bit_q    <= bit_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
      sh_a_q   <= sh_a_d;
      sh_b_q   <= sh_b_d;
      sh_c_q   <= sh_c_d;
      regdat_q <= regdat_d;
      regclk_q <= regclk_d;
      sla_q    <= sla_d;
      slb_q    <= slb_d;
      pdorun_q <= pdorun_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef ARPAS_DLY_RANGE_EN
      err_q    <= err_d;
`endif
    end
  end

  assign regdat = regdat_q;
  assign regclk = regclk_q;
  assign regsla = sla_q;
  assign regslb = slb_q;
  assign pdorun = pdorun_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_arpas_dly_loader.sv
// Directed bench for arpas_dly_loader: decodes the serial link on each regclk rise
// and compares against hand-computed words, timings and pulse counts.
module tb_arpas_dly_loader;

  logic sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  logic rstall, start, abort;
  logic [12:0] dly_a, dly_b, dly_c;
  logic regdat, regclk, regsla, regslb, pdorun, busy, done, err;

  logic r_start;
  logic [12:0] r_dly_a, r_dly_b, r_dly_c;
  logic r_regdat, r_regclk, r_regsla, r_regslb, r_pdorun, r_busy, r_done, r_err;

  arpas_dly_loader u_dut (
    .sysclk(sysclk), .rstall(rstall), .start(start), .abort(abort),
    .dly_a(dly_a), .dly_b(dly_b), .dly_c(dly_c),
    .regdat(regdat), .regclk(regclk), .regsla(regsla), .regslb(regslb),
    .pdorun(pdorun), .busy(busy), .done(done), .err(err)
  );

  arpas_dly_loader #(.RUN_LEN(100)) u_dut_r (
    .sysclk(sysclk), .rstall(rstall), .start(r_start), .abort(abort),
    .dly_a(r_dly_a), .dly_b(r_dly_b), .dly_c(r_dly_c),
    .regdat(r_regdat), .regclk(r_regclk), .regsla(r_regsla), .regslb(r_regslb),
    .pdorun(r_pdorun), .busy(r_busy), .done(r_done), .err(r_err)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  int ncyc, bad_sel, viol, pdo_rise, pdo_hi, done_cnt, busy_hi, clk_hi, selx;
  int pos[3];
  logic [12:0] rx[3];
  logic prev_dat, prev_clk, prev_sla, prev_slb, prev_pdo;
  int r_rise, r_busy_n, r_pdo_n, r_done_n;
  logic r_prev_clk;

  task automatic clear_mon();
    ncyc = 0; bad_sel = 0; viol = 0; pdo_rise = -1; pdo_hi = 0;
    done_cnt = 0; busy_hi = 0; clk_hi = 0; selx = 0;
    for (int k = 0; k < 3; k++) begin pos[k] = 0; rx[k] = '0; end
    prev_dat = regdat; prev_clk = regclk; prev_sla = regsla; prev_slb = regslb;
    prev_pdo = pdorun;
    r_rise = 0; r_busy_n = 0; r_pdo_n = 0; r_done_n = 0; r_prev_clk = r_regclk;
  endtask

  task automatic store(input int k);
    if (pos[k] < 13) rx[k][pos[k]] = regdat;
    pos[k]++;
  endtask

  task automatic tick();
    @(negedge sysclk);
    ncyc++;
    if (regclk) begin
      clk_hi++;
      if (regdat !== prev_dat || regsla !== prev_sla || regslb !== prev_slb) viol++;
    end
    if (regclk && !prev_clk) begin
      case ({regslb, regsla})
        2'b00:   store(0);
        2'b01:   store(1);
        2'b10:   store(2);
        default: bad_sel++;
      endcase
    end
    if (!regsla || !regslb) selx++;
    if (pdorun && !prev_pdo && pdo_rise < 0) pdo_rise = ncyc;
    if (pdorun) pdo_hi++;
    if (done) done_cnt++;
    if (busy) busy_hi++;
    if (r_regclk && !r_prev_clk) r_rise++;
    if (r_busy) r_busy_n++;
    if (r_pdorun) r_pdo_n++;
    if (r_done) r_done_n++;
    prev_dat = regdat; prev_clk = regclk; prev_sla = regsla; prev_slb = regslb;
    prev_pdo = pdorun; r_prev_clk = r_regclk;
  endtask

  task automatic check_full(input string tag);
    check({tag, "_word_a"}, int'(rx[0]), 13'h0001);
    check({tag, "_word_b"}, int'(rx[1]), 13'h1000);
    check({tag, "_word_c"}, int'(rx[2]), 13'h0AAA);
    check({tag, "_pulses_a"}, pos[0], 13);
    check({tag, "_pulses_b"}, pos[1], 13);
    check({tag, "_pulses_c"}, pos[2], 13);
    check({tag, "_idle_sel_pulse"}, bad_sel, 0);
    check({tag, "_hold_viol"}, viol, 0);
    check({tag, "_pdo_rise"}, pdo_rise, 166);
    check({tag, "_pdo_len"}, pdo_hi, 8192);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_busy_len"}, busy_hi, 8357);
  endtask

  initial begin
    rstall = 1'b0; start = 1'b0; abort = 1'b0;
    dly_a = '0; dly_b = '0; dly_c = '0;
    r_start = 1'b0; r_dly_a = '0; r_dly_b = '0; r_dly_c = '0;
    #12;
    check("rst_regdat", int'(regdat), 0);
    check("rst_regclk", int'(regclk), 0);
    check("rst_sla", int'(regsla), 1);
    check("rst_slb", int'(regslb), 1);
    check("rst_pdorun", int'(pdorun), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    @(negedge sysclk);
    rstall = 1'b1;

    // idle hold
    clear_mon();
    repeat (100) tick();
    check("idle_busy", busy_hi, 0);
    check("idle_pdo", pdo_hi, 0);
    check("idle_clk", clk_hi, 0);
    check("idle_sel", selx, 0);

    // single full load and fire
    dly_a = 13'h0001; dly_b = 13'h1000; dly_c = 13'h0AAA;
    start = 1'b1;
    clear_mon();
    tick();
    start = 1'b0;
    repeat (8400) tick();
    check_full("t1");
    check("t1_err", int'(err), 0);

    // second start mid-load ignored, input changes shadowed
    start = 1'b1;
    clear_mon();
    tick();
    start = 1'b0;
    for (int i = 1; i <= 8400; i++) begin
      tick();
      if (i == 50) start = 1'b1;
      if (i == 51) start = 1'b0;
      if (i == 60) begin dly_a = 13'h1FFF; dly_b = 13'h0555; dly_c = 13'h0000; end
    end
    check_full("t2");
    dly_a = 13'h0001; dly_b = 13'h1000; dly_c = 13'h0AAA;

    // abort during channel B bit 6
    start = 1'b1;
    clear_mon();
    tick();
    start = 1'b0;
    for (int i = 0; i < 300 && pos[1] < 7; i++) tick();
    check("abort_reach_b6", int'(pos[1] >= 7 && regclk), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_regclk", int'(regclk), 0);
    check("abort_sla", int'(regsla), 1);
    check("abort_slb", int'(regslb), 1);
    check("abort_busy", int'(busy), 0);
    repeat (400) tick();
    check("abort_pdo", pdo_hi, 0);
    check("abort_done", done_cnt, 0);
    check("abort_err", int'(err), 0);

    // async reset during RUN, then a clean restart
    start = 1'b1;
    clear_mon();
    tick();
    start = 1'b0;
    repeat (200) tick();
    check("arst_pdo_before", int'(pdorun), 1);
    #1 rstall = 1'b0;
    #1;
    check("arst_pdo", int'(pdorun), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_sla", int'(regsla), 1);
    tick();
    rstall = 1'b1;
    repeat (3) tick();
    start = 1'b1;
    clear_mon();
    tick();
    start = 1'b0;
    repeat (8400) tick();
    check_full("t4");

    // range check on the short-window instance
    r_dly_a = 13'd1; r_dly_b = 13'd2; r_dly_c = 13'd100;
    r_start = 1'b1;
    clear_mon();
    tick();
    r_start = 1'b0;
    repeat (400) tick();
`ifdef ARPAS_DLY_RANGE_EN
    check("rng_err", int'(r_err), 1);
    check("rng_busy", r_busy_n, 0);
    check("rng_clk", r_rise, 0);
    check("rng_pdo", r_pdo_n, 0);
`else
    check("rng_err", int'(r_err), 0);
    check("rng_clk", r_rise, 39);
    check("rng_pdo", r_pdo_n, 100);
    check("rng_done", r_done_n, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/arpas_dly_loader.md
Name: arpas_dly_loader

Overview:
Upstream feeder for the three-channel PAS timer. Takes three parallel 13-bit channel delay words and a start pulse. Serially loads each word into its timer channel over the regdat/regclk/regsla/regslb link, then asserts pdorun for a fixed firing window. All link outputs are registered and glitch-free, so the timer's channel clocks see clean pulses only.

Parameters:
DW, 13, delay word width; equals timer register depth.
HALF, 2, sysclk cycles per regclk half-period; legal range 1..15.
RUN_LEN, 8192, pdorun high time in sysclk cycles; legal range 1..16383.
SETTLE, 2, sysclk cycles that the select lines are held stable before the first regclk of a channel.

Ports:
sysclk  in  1  system clock; all logic on rising edge.
rstall  in  1  asynchronous, active-low reset.
start  in  1  one-cycle request to load and fire.
abort  in  1  synchronous abort; wins over every other event.
dly_a  in  DW  channel A delay in sysclk counts.
dly_b  in  DW  channel B delay.
dly_c  in  DW  channel C delay.
regdat  out  1  serial delay data to the timer.
regclk  out  1  serial load strobe to the timer.
regsla  out  1  channel select bit 0.
regslb  out  1  channel select bit 1.
pdorun  out  1  timer run enable (firing window).
busy  out  1  high from accepted start until return to IDLE.
done  out  1  one-cycle pulse when a firing window completes normally.
err  out  1  sticky range error (see Optional Feature).

Behaviour:
- Reset (rstall=0), asynchronous: regdat=0, regclk=0, regsla=1, regslb=1, pdorun=0, busy=0, done=0, err=0; state=IDLE.
- Select 11 is the idle code and addresses no channel. Channel codes: A=00, B=10 (sla=1), C=01 (slb=1).
- IDLE: busy=0.
  - start=1 snapshots dly_a/b/c into shadow registers.
  - Next cycle: busy=1, channel=A, go to SETUP.
- SETUP: drive the channel select code and hold it SETTLE cycles. Bit index=0. Go to SHIFT_LO.
- SHIFT_LO: regdat = shadow[bit index], LSB first; regclk=0; lasts HALF cycles. Go to SHIFT_HI.
- SHIFT_HI: regclk=1; regdat and select held unchanged; lasts HALF cycles.
  - If bit index < DW-1: increment bit index, go to SHIFT_LO.
  - Otherwise go to NEXTCH.
- NEXTCH: regclk=0; select returns to 11 for 1 cycle.
  - After A, go to SETUP for B; after B, go to SETUP for C; after C, go to RUN.
- RUN: select=11, regdat=0, pdorun=1 for exactly RUN_LEN cycles. Then pdorun=0, done=1 for 1 cycle, go to IDLE.
- Load timing:
  - Per channel: SETTLE + DW*2*HALF + 1 cycles.
  - With defaults, start to pdorun rise = 1 + 3*(2+52+1) = 166 cycles.
- Rule: regdat and select never change in the same cycle that regclk rises or is high.
- start while busy=1 is ignored; no queueing. dly_* changes while busy have no effect (shadowed).
- abort=1 in any state: next cycle is IDLE with reset output values; done not pulsed; err unchanged. abort and start in the same cycle: abort wins and start is dropped.
- Async reset mid-shift forces reset values immediately. A regclk pulse in progress is truncated; the timer's own reset handles partial loads.
- Counters: bit index 4 bits, half-period counter 4 bits, run counter 14 bits. All saturate-free, reload on state entry, no wrap beyond their terminal count.

Optional Feature:
Macro ARPAS_DLY_RANGE_EN.
- Defined:
  - At start accept, any shadow word >= RUN_LEN sets err=1 (sticky until reset), and the request is rejected: busy stays 0 and there is no link activity.
  - A channel whose delay is not below the run window would never fire.
- Undefined: no check is made, err is tied to 0, and all words are loaded as given.

Test Plan:
- Reset release, no start -> sla=slb=1, regclk=0, pdorun=0, busy=0 held for 100 cycles.
- start with dly_a=13'h0001, dly_b=13'h1000, dly_c=13'h0AAA, defaults -> 13 regclk pulses per channel. Data captured on regclk rise is LSB first: A: 1,0,0,...,0; B: 0,...,0,1; C: 0,1,0,1,... Selects are 00/10/01. pdorun rises at cycle 166, is high 8192 cycles, and done pulses once.
- start asserted again at cycle 50 of a load -> ignored; bitstream identical to the single-start case.
- abort during channel B bit 6 -> next cycle regclk=0, select=11, busy=0. pdorun never rises and done stays 0.
- rstall pulled low during RUN -> pdorun=0 asynchronously, without waiting for a clock edge. After release, a new start completes a normal sequence.
- With ARPAS_DLY_RANGE_EN, RUN_LEN=100, dly_c=100 -> err=1, busy stays 0, no regclk edges. Without the macro, the same stimulus loads normally and err=0.
